// File: rtl/rob_commit_unit.sv
// rob_commit_unit
// Reorder buffer for the Tomasulo core. Hands out an alias (ROB id, 1..ROB_SIZE)
// to every dispatched instruction, collects results from the CDB, and retires
// entries strictly in program order, one per cycle, into the register file's
// commit port. A retiring mispredicted branch still commits its link register,
// then the unit spends one FLUSH cycle clearing itself and pulses rollback.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global ready; low freezes all state
//   issue_*             dispatcher allocation request (valid, rd, branch info, pc, store)
//   issue_id            alias the next accepted issue will receive (tail + 1)
//   rob_full            registered occupancy equals ROB_SIZE
//   query_id1/2         operand aliases; query_ready1/2, query_val1/2 answer them
//   cdb_*               execution result broadcast (id, value, branch outcome)
//   commit_*            register-file write port (valid, rd, value, alias)
//   store_commit        one-cycle pulse allowing the head store to write memory
//   rollback_signal/pc  one-cycle flush pulse and fetch redirect target
module rob_commit_unit #(
   parameter int ROB_SIZE = 16,
   parameter int ID_W     = 5,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic            issue_is_branch,
   input  logic            issue_pred_taken,
   input  logic [XLEN-1:0] issue_pc,
   input  logic            issue_is_store,
   output logic [ID_W-1:0] issue_id,
   output logic            rob_full,
   input  logic [ID_W-1:0] query_id1,
   input  logic [ID_W-1:0] query_id2,
   output logic            query_ready1,
   output logic            query_ready2,
   output logic [XLEN-1:0] query_val1,
   output logic [XLEN-1:0] query_val2,
   input  logic            cdb_valid,
   input  logic [ID_W-1:0] cdb_id,
   input  logic [XLEN-1:0] cdb_value,
   input  logic            cdb_taken,
   input  logic [XLEN-1:0] cdb_target,
   output logic            commit_valid,
   output logic [4:0]      commit_rd,
   output logic [XLEN-1:0] commit_value,
   output logic [ID_W-1:0] commit_id,
   output logic            store_commit,
   output logic            rollback_signal,
   output logic [XLEN-1:0] rollback_pc
);

   localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
   localparam int CNT_W = $clog2(ROB_SIZE + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROB_SIZE - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_SIZE);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;
   state_t state_q, state_d;

   logic [IDX_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;

   logic [ROB_SIZE-1:0] busy_q, ready_q, is_branch_q, pred_q, taken_q, is_store_q;
   logic [4:0]          rd_q     [ROB_SIZE];
   logic [XLEN-1:0]     value_q  [ROB_SIZE];
   logic [XLEN-1:0]     target_q [ROB_SIZE];
   logic [XLEN-1:0]     pc_q     [ROB_SIZE];

   // Aliases are 1-based; id 0 means "no producer", so it never maps to an entry.
   function automatic logic id_in_range(input logic [ID_W-1:0] id);
      return (id != '0) && (int'(id) <= ROB_SIZE);
   endfunction

   function automatic logic [IDX_W-1:0] id_to_idx(input logic [ID_W-1:0] id);
      return IDX_W'(id - ID_W'(1));
   endfunction

   logic [IDX_W-1:0] cdb_idx;
   logic             run_cycle, issue_accept, cdb_accept, head_retire, head_mispredict;

   assign rob_full        = (count_q == FULL_CNT);
   assign issue_id        = ID_W'(tail_q) + ID_W'(1);
   assign cdb_idx         = id_to_idx(cdb_id);
   assign run_cycle       = rdy && (state_q == ST_RUN);
   assign issue_accept    = run_cycle && issue_valid && !rob_full;
   assign cdb_accept      = run_cycle && cdb_valid && id_in_range(cdb_id) && busy_q[cdb_idx];
   assign head_retire     = run_cycle && busy_q[head_q] && ready_q[head_q];
   assign head_mispredict = is_branch_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

   // Operand lookup: a same-cycle CDB broadcast wins over the stored value so a
   // consumer dispatched alongside the broadcast does not miss it.
   function automatic logic [XLEN:0] lookup(input logic [ID_W-1:0] id);
      logic [IDX_W-1:0] idx;
      idx = id_to_idx(id);
      if (id == '0)
         return {1'b1, {XLEN{1'b0}}};
      else if (cdb_valid && (cdb_id == id))
         return {1'b1, cdb_value};
      else if (id_in_range(id) && ready_q[idx])
         return {1'b1, value_q[idx]};
      else
         return {1'b0, {XLEN{1'b0}}};
   endfunction

   // Both register-file operand ports are answered combinationally.
   always_comb begin
      {query_ready1, query_val1} = lookup(query_id1);
      {query_ready2, query_val2} = lookup(query_id2);
   end

   // Next-state logic: a retiring mispredicted branch sends the unit into a
   // single FLUSH cycle; rdy low holds whatever state we are in.
   always_comb begin
      state_d = state_q;
      if (rdy) begin
         case (state_q)
            ST_RUN:   if (head_retire && head_mispredict) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   // Buffer storage, pointers and registered commit/rollback outputs. The
   // mispredicted branch commits on the edge that enters FLUSH; the FLUSH edge
   // then clears everything and raises rollback, so the two never overlap.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         busy_q          <= '0;
         ready_q         <= '0;
         commit_valid    <= 1'b0;
         commit_rd       <= '0;
         commit_value    <= '0;
         commit_id       <= '0;
         store_commit    <= 1'b0;
         rollback_signal <= 1'b0;
         rollback_pc     <= '0;
      end else if (!rdy) begin
         commit_valid    <= 1'b0;
         store_commit    <= 1'b0;
         rollback_signal <= 1'b0;
      end else if (state_q == ST_FLUSH) begin
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         busy_q          <= '0;
         ready_q         <= '0;
         commit_valid    <= 1'b0;
         store_commit    <= 1'b0;
         rollback_signal <= 1'b1;
      end else begin
         commit_valid    <= 1'b0;
         store_commit    <= 1'b0;
         rollback_signal <= 1'b0;

         if (cdb_accept) begin
            value_q[cdb_idx]  <= cdb_value;
            taken_q[cdb_idx]  <= cdb_taken;
            target_q[cdb_idx] <= cdb_target;
            ready_q[cdb_idx]  <= 1'b1;
         end

         if (issue_accept) begin
            busy_q[tail_q]      <= 1'b1;
            ready_q[tail_q]     <= 1'b0;
            rd_q[tail_q]        <= issue_rd;
            is_branch_q[tail_q] <= issue_is_branch;
            pred_q[tail_q]      <= issue_pred_taken;
            pc_q[tail_q]        <= issue_pc;
            is_store_q[tail_q]  <= issue_is_store;
            tail_q <= (tail_q == LAST_IDX) ? '0 : tail_q + IDX_W'(1);
         end

         if (head_retire) begin
            commit_valid <= (rd_q[head_q] != 5'd0) && !is_store_q[head_q];
            store_commit <= is_store_q[head_q];
            commit_rd    <= rd_q[head_q];
            commit_value <= value_q[head_q];
            commit_id    <= ID_W'(head_q) + ID_W'(1);
            busy_q[head_q]  <= 1'b0;
            ready_q[head_q] <= 1'b0;
            if (head_mispredict)
               rollback_pc <= taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + XLEN'(4);
            head_q <= (head_q == LAST_IDX) ? '0 : head_q + IDX_W'(1);
         end

         if (issue_accept && !head_retire)
            count_q <= count_q + CNT_W'(1);
         else if (!issue_accept && head_retire)
            count_q <= count_q - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_rob_commit_unit.sv
// tb_rob_commit_unit
// Directed bench for rob_commit_unit: in-order retirement, full/wrap handling,
// CDB operand bypass, branch rollback (taken and not-taken mispredictions and a
// correct prediction), store retirement and the rdy freeze.
module tb_rob_commit_unit;

   logic        clk, rst, rdy;
   logic        issue_valid, issue_is_branch, issue_pred_taken, issue_is_store;
   logic [4:0]  issue_rd;
   logic [31:0] issue_pc;
   logic [4:0]  issue_id;
   logic        rob_full;
   logic [4:0]  query_id1, query_id2;
   logic        query_ready1, query_ready2;
   logic [31:0] query_val1, query_val2;
   logic        cdb_valid, cdb_taken;
   logic [4:0]  cdb_id;
   logic [31:0] cdb_value, cdb_target;
   logic        commit_valid, store_commit, rollback_signal;
   logic [4:0]  commit_rd, commit_id;
   logic [31:0] commit_value, rollback_pc;

   int checks   = 0;
   int failures = 0;

   rob_commit_unit #(.ROB_SIZE(16), .ID_W(5), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_is_branch(issue_is_branch), .issue_pred_taken(issue_pred_taken),
      .issue_pc(issue_pc), .issue_is_store(issue_is_store),
      .issue_id(issue_id), .rob_full(rob_full),
      .query_id1(query_id1), .query_id2(query_id2),
      .query_ready1(query_ready1), .query_ready2(query_ready2),
      .query_val1(query_val1), .query_val2(query_val2),
      .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value),
      .cdb_taken(cdb_taken), .cdb_target(cdb_target),
      .commit_valid(commit_valid), .commit_rd(commit_rd),
      .commit_value(commit_value), .commit_id(commit_id),
      .store_commit(store_commit),
      .rollback_signal(rollback_signal), .rollback_pc(rollback_pc)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One clock edge; inputs are driven and outputs sampled 1 unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic apply_issue(input logic [4:0] rd, input logic br, input logic pred,
                              input logic [31:0] pc, input logic st);
      issue_valid      = 1'b1;
      issue_rd         = rd;
      issue_is_branch  = br;
      issue_pred_taken = pred;
      issue_pc         = pc;
      issue_is_store   = st;
      tick();
      issue_valid = 1'b0;
   endtask

   task automatic apply_cdb(input logic [4:0] id, input logic [31:0] value,
                            input logic taken, input logic [31:0] target);
      cdb_valid  = 1'b1;
      cdb_id     = id;
      cdb_value  = value;
      cdb_taken  = taken;
      cdb_target = target;
      tick();
      cdb_valid = 1'b0;
   endtask

   initial begin
      rdy = 1'b1; rst = 1'b0;
      issue_valid = 1'b0; issue_rd = '0; issue_is_branch = 1'b0;
      issue_pred_taken = 1'b0; issue_pc = '0; issue_is_store = 1'b0;
      query_id1 = '0; query_id2 = '0;
      cdb_valid = 1'b0; cdb_id = '0; cdb_value = '0; cdb_taken = 1'b0; cdb_target = '0;

      // Reset state
      apply_reset();
      check_output("rst_commit_valid", 32'(commit_valid), 32'd0);
      check_output("rst_store_commit", 32'(store_commit), 32'd0);
      check_output("rst_rollback", 32'(rollback_signal), 32'd0);
      check_output("rst_rollback_pc", rollback_pc, 32'd0);
      check_output("rst_rob_full", 32'(rob_full), 32'd0);
      check_output("rst_issue_id", 32'(issue_id), 32'd1);

      // In-order commit with out-of-order CDB results
      apply_issue(5'd5, 1'b0, 1'b0, 32'h0, 1'b0);
      check_output("t1_issue_id_2", 32'(issue_id), 32'd2);
      apply_issue(5'd6, 1'b0, 1'b0, 32'h4, 1'b0);
      check_output("t1_issue_id_3", 32'(issue_id), 32'd3);
      apply_issue(5'd0, 1'b0, 1'b0, 32'h8, 1'b0);
      check_output("t1_issue_id_4", 32'(issue_id), 32'd4);
      apply_cdb(5'd2, 32'hAA, 1'b0, 32'h0);
      check_output("t1_no_commit_out_of_order", 32'(commit_valid), 32'd0);
      apply_cdb(5'd1, 32'h11, 1'b0, 32'h0);
      check_output("t1_commit_is_registered", 32'(commit_valid), 32'd0);
      tick();
      check_output("t1_c1_valid", 32'(commit_valid), 32'd1);
      check_output("t1_c1_rd", 32'(commit_rd), 32'd5);
      check_output("t1_c1_value", commit_value, 32'h11);
      check_output("t1_c1_id", 32'(commit_id), 32'd1);
      tick();
      check_output("t1_c2_valid", 32'(commit_valid), 32'd1);
      check_output("t1_c2_rd", 32'(commit_rd), 32'd6);
      check_output("t1_c2_value", commit_value, 32'hAA);
      check_output("t1_c2_id", 32'(commit_id), 32'd2);
      apply_cdb(5'd3, 32'h33, 1'b0, 32'h0);
      check_output("t1_head3_not_yet", 32'(commit_valid), 32'd0);
      tick();
      check_output("t1_c3_id", 32'(commit_id), 32'd3);
      check_output("t1_c3_rd0_no_write", 32'(commit_valid), 32'd0);

      // Fill, ignored 17th issue, retire one while issuing, wrap
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         if (i == 15) check_output("t2_not_full_at_15", 32'(rob_full), 32'd0);
         apply_issue(5'(i + 1), 1'b0, 1'b0, 32'(i * 4), 1'b0);
      end
      check_output("t2_full", 32'(rob_full), 32'd1);
      check_output("t2_full_issue_id", 32'(issue_id), 32'd1);
      apply_issue(5'd20, 1'b0, 1'b0, 32'h400, 1'b0);
      check_output("t2_17th_tail_unchanged", 32'(issue_id), 32'd1);
      check_output("t2_17th_still_full", 32'(rob_full), 32'd1);
      apply_cdb(5'd1, 32'h100, 1'b0, 32'h0);
      check_output("t2_full_before_retire", 32'(rob_full), 32'd1);
      issue_valid = 1'b1; issue_rd = 5'd21;
      tick();
      issue_valid = 1'b0;
      check_output("t2_retire_valid", 32'(commit_valid), 32'd1);
      check_output("t2_retire_rd", 32'(commit_rd), 32'd1);
      check_output("t2_retire_value", commit_value, 32'h100);
      check_output("t2_not_full_after_retire", 32'(rob_full), 32'd0);
      check_output("t2_same_cycle_issue_ignored", 32'(issue_id), 32'd1);
      apply_issue(5'd22, 1'b0, 1'b0, 32'h500, 1'b0);
      check_output("t2_wrap_issue_id", 32'(issue_id), 32'd2);
      check_output("t2_full_again", 32'(rob_full), 32'd1);

      // Operand queries with CDB bypass
      query_id1 = 5'd4; query_id2 = 5'd5;
      #1;
      check_output("t3_q1_not_ready", 32'(query_ready1), 32'd0);
      cdb_valid = 1'b1; cdb_id = 5'd4; cdb_value = 32'hDEAD;
      cdb_taken = 1'b0; cdb_target = 32'h0;
      #1;
      check_output("t3_bypass_ready", 32'(query_ready1), 32'd1);
      check_output("t3_bypass_value", query_val1, 32'hDEAD);
      check_output("t3_q2_not_ready", 32'(query_ready2), 32'd0);
      tick();
      cdb_valid = 1'b0;
      #1;
      check_output("t3_stored_ready", 32'(query_ready1), 32'd1);
      check_output("t3_stored_value", query_val1, 32'hDEAD);
      query_id2 = 5'd0;
      #1;
      check_output("t3_id0_ready", 32'(query_ready2), 32'd1);
      check_output("t3_id0_value", query_val2, 32'd0);
      query_id1 = '0; query_id2 = '0;

      // Predicted not-taken branch resolves taken
      apply_reset();
      apply_issue(5'd1, 1'b1, 1'b0, 32'h100, 1'b0);
      apply_issue(5'd7, 1'b0, 1'b0, 32'h104, 1'b0);
      apply_cdb(5'd1, 32'h104, 1'b1, 32'h200);
      check_output("t4_pre_commit", 32'(commit_valid), 32'd0);
      tick();
      check_output("t4_n_commit_valid", 32'(commit_valid), 32'd1);
      check_output("t4_n_commit_rd", 32'(commit_rd), 32'd1);
      check_output("t4_n_commit_value", commit_value, 32'h104);
      check_output("t4_n_no_rollback", 32'(rollback_signal), 32'd0);
      issue_valid = 1'b1; issue_rd = 5'd8; issue_is_branch = 1'b0; issue_pc = 32'h108;
      tick();
      issue_valid = 1'b0;
      check_output("t4_n1_rollback", 32'(rollback_signal), 32'd1);
      check_output("t4_n1_rollback_pc", rollback_pc, 32'h200);
      check_output("t4_n1_no_commit", 32'(commit_valid), 32'd0);
      check_output("t4_n1_flushed_issue_id", 32'(issue_id), 32'd1);
      check_output("t4_n1_not_full", 32'(rob_full), 32'd0);
      tick();
      check_output("t4_rollback_one_cycle", 32'(rollback_signal), 32'd0);

      // Predicted taken branch resolves not-taken, then a correct prediction
      apply_issue(5'd0, 1'b1, 1'b1, 32'h40, 1'b0);
      apply_cdb(5'd1, 32'h0, 1'b0, 32'h80);
      tick();
      check_output("t5_n_commit_id", 32'(commit_id), 32'd1);
      check_output("t5_n_no_rollback", 32'(rollback_signal), 32'd0);
      tick();
      check_output("t5_nt_rollback", 32'(rollback_signal), 32'd1);
      check_output("t5_nt_rollback_pc", rollback_pc, 32'h44);
      tick();
      apply_issue(5'd0, 1'b1, 1'b1, 32'h60, 1'b0);
      apply_cdb(5'd1, 32'h0, 1'b1, 32'h90);
      tick();
      check_output("t5_ok_commit_id", 32'(commit_id), 32'd1);
      tick();
      check_output("t5_ok_no_rollback", 32'(rollback_signal), 32'd0);
      check_output("t5_ok_no_flush", 32'(issue_id), 32'd2);

      // Store retirement
      check_output("t6_store_id", 32'(issue_id), 32'd2);
      apply_issue(5'd3, 1'b0, 1'b0, 32'h70, 1'b1);
      apply_cdb(5'd2, 32'h5, 1'b0, 32'h0);
      tick();
      check_output("t6_store_commit", 32'(store_commit), 32'd1);
      check_output("t6_store_no_regwrite", 32'(commit_valid), 32'd0);
      check_output("t6_store_id_out", 32'(commit_id), 32'd2);
      tick();
      check_output("t6_store_pulse_ends", 32'(store_commit), 32'd0);

      // rdy low freezes a ready head
      apply_issue(5'd9, 1'b0, 1'b0, 32'h74, 1'b0);
      apply_cdb(5'd3, 32'h99, 1'b0, 32'h0);
      rdy = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd10; issue_is_store = 1'b0;
      tick();
      check_output("t6_frozen_1", 32'(commit_valid), 32'd0);
      tick();
      check_output("t6_frozen_2", 32'(commit_valid), 32'd0);
      check_output("t6_frozen_head", 32'(commit_id), 32'd2);
      check_output("t6_frozen_tail", 32'(issue_id), 32'd4);
      issue_valid = 1'b0;
      rdy = 1'b1;
      tick();
      check_output("t6_resume_valid", 32'(commit_valid), 32'd1);
      check_output("t6_resume_rd", 32'(commit_rd), 32'd9);
      check_output("t6_resume_value", commit_value, 32'h99);
      check_output("t6_resume_id", 32'(commit_id), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer of the Tomasulo core, sitting between dispatcher/CDB and the register file.
- Allocates an alias (ROB id) per dispatched instruction and collects results from the CDB.
- Retires in program order, one per cycle, driving the register file's commit port (rob_has_res / result / regidx / regalias) and its rollback input.
- On a mispredicted branch, commits the branch and then flushes the whole machine.

Parameters:
ROB_SIZE, 16, number of entries; ids are 1..ROB_SIZE; id 0 means "no alias / value ready"
ID_W, 5, alias width; must satisfy 2^ID_W > ROB_SIZE
XLEN, 32, data/PC width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; low freezes all state
issue_valid  in  1  dispatcher allocates an entry this cycle
issue_rd  in  5  destination register (0 = none)
issue_is_branch  in  1  entry is a conditional branch/jump
issue_pred_taken  in  1  predicted direction
issue_pc  in  XLEN  instruction PC
issue_is_store  in  1  entry is a store
issue_id  out  ID_W  id allocated on the next issue (combinational: tail index + 1)
rob_full  out  1  count == ROB_SIZE
query_id1, query_id2  in  ID_W  operand aliases from the register file
query_ready1, query_ready2  out  1  alias value available (id 0 -> 1)
query_val1, query_val2  out  XLEN  forwarded value
cdb_valid  in  1  execution result broadcast
cdb_id  in  ID_W  producing entry
cdb_value  in  XLEN  result
cdb_taken  in  1  actual branch outcome
cdb_target  in  XLEN  actual taken target
commit_valid  out  1  register-file write strobe (rob_has_res)
commit_rd  out  5  destination (regidx_from_rob)
commit_value  out  XLEN  value (result_from_rob)
commit_id  out  ID_W  retiring alias (regalias_from_rob)
store_commit  out  1  one-cycle pulse: head store may write memory
rollback_signal  out  1  one-cycle flush pulse
rollback_pc  out  XLEN  fetch redirect PC, valid with rollback_signal

Behaviour:
- Circular buffer with head, tail and count registers.
- Per-entry state: busy, ready, rd, value, is_branch, pred, taken, target, pc, is_store.
- Reset: head = tail = count = 0, all busy/ready = 0, every output register 0, FSM = RUN.
- rdy low: no state change; commit_valid, store_commit and rollback_signal are 0.
- Issue: with issue_valid && !rob_full, entry[tail] is written busy=1, ready=0 and tail advances, wrapping ROB_SIZE-1 -> 0.
- Issue while full is ignored. rob_full is computed from the registered count, so a commit in the same cycle does not admit the issue.
- CDB: with cdb_valid and entry[cdb_id-1] busy, that entry records value, taken, target and sets ready=1.
- A CDB write to a non-busy entry is dropped.
- Query: ready = (id == 0) or entry ready or (cdb_valid && cdb_id == id).
  - Value priority: CDB bypass, then entry value, then 0 when id == 0.
- FSM states RUN and FLUSH.
- RUN, with head entry busy && ready, retires that entry.
  - Retirement is registered: the entry's outputs appear the cycle after it becomes ready at head, or after the CDB write for that entry at head.
  - Outputs: commit_valid = (rd != 0 && !is_store), commit_rd, commit_value, commit_id = head+1.
  - Stores assert store_commit instead of commit_valid.
  - head advances and count decrements.
- Throughput: at most one retirement per cycle. Simultaneous issue and retire leaves count unchanged.
- Misprediction: a retiring branch with taken != pred is mispredicted.
  - It still commits its rd (JAL link) in cycle N.
  - The FSM enters FLUSH and rollback_signal = 1 in cycle N+1.
  - rollback_pc = taken ? target : pc+4.
- FLUSH (one cycle): clear all busy/ready, head = tail = count = 0, ignore issue and CDB, no commit; return to RUN.
- Rollback and commit are never asserted in the same cycle. The register file gives rollback priority over its write.
- Wrap-around: head and tail wrap independently. Empty is count == 0, not head == tail.

Test Plan:
- Reset, then issue 3 entries (rd = 5, 6, 0) -> issue_id sequence 1, 2, 3; CDB id 2 value 0xAA then id 1 value 0x11 -> commits in order: (rd5, 0x11, id1) then (rd6, 0xAA, id2); id3 retires with commit_valid = 0.
- Fill 16 entries -> rob_full = 1; 17th issue ignored and tail unchanged; retire one -> rob_full = 0 and next issue_id = 1 (wrap).
- Query id 4 while the CDB broadcasts id 4 = 0xDEAD the same cycle -> query_ready1 = 1, query_val1 = 0xDEAD; query id 0 -> ready = 1.
- Branch at pc 0x100 predicted not-taken, CDB taken = 1, target = 0x200, rd = 1 -> cycle N commit rd1, cycle N+1 rollback_signal = 1 with rollback_pc = 0x200, count = 0, no commit in N+1.
- Predicted-taken branch resolving not-taken at pc 0x40 -> rollback_pc = 0x44; a correctly predicted branch -> no rollback.
- Store entry retires -> store_commit pulse, commit_valid = 0; hold rdy = 0 two cycles with a ready head -> no retirement until rdy returns.
